// File: rtl/dct_quant_zigzag.sv
// Quantizes one snapshotted 8x8 DCT block with the JPEG luma table through a
// reciprocal multiply, then streams the coefficients in zigzag order over valid/ready.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no block held; a dct_valid strobe captures all 64 coefficients
// RUN   | block held; zigzag reads feed the 2-stage pipe until beat 63 handshakes
module dct_quant_zigzag #(
  parameter int DW = 10,
  parameter int RW = 13
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          dct_valid,
  input  logic [DW-1:0] dct_data [0:63],
  output logic          busy,
  output logic          coef_valid,
  input  logic          coef_ready,
  output logic [DW-1:0] coef_data,
  output logic [5:0]    coef_index,
  output logic          coef_last,
  output logic          block_done
);

  localparam int PW = DW + RW + 1;

  localparam logic [5:0] ZZ_TAB [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  localparam int Q_TAB [64] = '{
    16, 11, 10, 16, 24,  40,  51,  61,
    12, 12, 14, 19, 26,  58,  60,  55,
    14, 13, 16, 24, 40,  57,  69,  56,
    14, 17, 22, 29, 51,  87,  80,  62,
    18, 22, 37, 56, 68,  109, 103, 77,
    24, 35, 55, 64, 81,  104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99
  };

  // Elaboration-time ROM: (2*65536 + Q) / (2*Q) is round(65536/Q).
  function automatic logic [64*RW-1:0] gen_recip();
    logic [64*RW-1:0] v;
    v = '0;
    for (int i = 0; i < 64; i++)
      v[i*RW +: RW] = RW'((131072 + Q_TAB[i]) / (2 * Q_TAB[i]));
    return v;
  endfunction

  localparam logic [64*RW-1:0] R_PACKED = gen_recip();

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [DW-1:0] blk_buf [64];
  logic [5:0]    rd_k;
  logic          issue_done;
  logic          s1_valid;
  logic [PW-1:0] s1_prod;
  logic          s1_neg;
  logic [5:0]    s1_k;

  logic          capture, advance, issue, fire_last;
  logic [5:0]    rd_addr;
  logic [DW-1:0] rd_x;
  logic [DW:0]   rd_xs, rd_mag;
  logic [RW-1:0] rd_recip;
  logic [PW:0]   rnd;
  logic [DW-1:0] p_mag;

  always_comb begin
    capture   = (state == IDLE) && dct_valid;
    advance   = !coef_valid || coef_ready;
    issue     = (state == RUN) && !issue_done && advance;
    fire_last = coef_valid && coef_ready && coef_last;
    rd_addr   = ZZ_TAB[rd_k];
    rd_x      = blk_buf[rd_addr];
    // Sign-extend before negating so -512 yields magnitude 512.
    rd_xs     = {rd_x[DW-1], rd_x};
    rd_mag    = rd_x[DW-1] ? -rd_xs : rd_xs;
    rd_recip  = R_PACKED[int'(rd_addr)*RW +: RW];
    rnd       = {1'b0, s1_prod} + (PW+1)'(32'h8000);
    p_mag     = DW'(rnd >> 16);
  end

  always_ff @(posedge clock) begin
    if (capture) blk_buf <= dct_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      rd_k       <= '0;
      issue_done <= 1'b0;
      s1_valid   <= 1'b0;
      s1_prod    <= '0;
      s1_neg     <= 1'b0;
      s1_k       <= '0;
      coef_valid <= 1'b0;
      coef_data  <= '0;
      coef_index <= '0;
      coef_last  <= 1'b0;
      block_done <= 1'b0;
    end else begin
      block_done <= fire_last;
      case (state)
        IDLE: if (capture) begin
          state      <= RUN;
          busy       <= 1'b1;
          rd_k       <= '0;
          issue_done <= 1'b0;
        end
        RUN: if (fire_last) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (issue) begin
        rd_k <= rd_k + 6'd1;
        if (rd_k == 6'd63) issue_done <= 1'b1;
      end

      // Both stages move together, so a stalled output freezes the whole pipe.
      if (advance) begin
        s1_valid <= issue;
        if (issue) begin
          s1_prod <= PW'(rd_mag) * PW'(rd_recip);
          s1_neg  <= rd_x[DW-1];
          s1_k    <= rd_k;
        end
        coef_valid <= s1_valid;
        if (s1_valid) begin
          coef_data  <= s1_neg ? -p_mag : p_mag;
          coef_index <= s1_k;
          coef_last  <= (s1_k == 6'd63);
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Scoreboard bench for dct_quant_zigzag: stimulus pushes expected zigzag beats,
// a negedge monitor pops and compares on every handshake.
module tb_dct_quant_zigzag;

  typedef logic [9:0] blk_t [64];
  typedef struct {
    int idx;
    int data;
    bit last;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       dct_valid = 1'b0;
  blk_t       dct_data;
  logic       busy, coef_valid, coef_last, block_done;
  logic       coef_ready = 1'b1;
  logic [9:0] coef_data;
  logic [5:0] coef_index;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   ready_mode = 1'b0;
  exp_t sb[$];
  int   zz [64];
  int   recip [64];

  localparam int QL [64] = '{
    16, 11, 10, 16, 24,  40,  51,  61,
    12, 12, 14, 19, 26,  58,  60,  55,
    14, 13, 16, 24, 40,  57,  69,  56,
    14, 17, 22, 29, 51,  87,  80,  62,
    18, 22, 37, 56, 68,  109, 103, 77,
    24, 35, 55, 64, 81,  104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99
  };

  dct_quant_zigzag #(.DW(10), .RW(13)) dut (
    .clock(clock), .reset(reset), .dct_valid(dct_valid), .dct_data(dct_data),
    .busy(busy), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_data(coef_data), .coef_index(coef_index), .coef_last(coef_last),
    .block_done(block_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name, input int act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0d, expected none (cycle %0d)", name, act, cyc);
  endfunction

  // Reference: diagonal zigzag walk and round(65536/Q) from real arithmetic.
  function automatic void build_model();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = 7; r >= 0; r--)
          if (s - r >= 0 && s - r < 8) begin zz[n] = r * 8 + s - r; n++; end
      end else begin
        for (int r = 0; r < 8; r++)
          if (s - r >= 0 && s - r < 8) begin zz[n] = r * 8 + s - r; n++; end
      end
    end
    for (int a = 0; a < 64; a++) recip[a] = $rtoi(65536.0 / QL[a] + 0.5);
  endfunction

  function automatic void push_expected(input blk_t blk);
    for (int k = 0; k < 64; k++) begin
      int x, m, p;
      exp_t e;
      x = int'($signed(blk[zz[k]]));
      m = (x < 0) ? -x : x;
      p = (m * recip[zz[k]] + 32768) / 65536;
      e.idx  = k;
      e.data = (x < 0) ? -p : p;
      e.last = (k == 63);
      sb.push_back(e);
    end
  endfunction

  // Ready driver: held high, or a fair coin each cycle.
  initial begin
    forever begin
      @(posedge clock);
      #1 coef_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare on handshakes, check holds under stall and the done pulse.
  bit         prev_fire = 1'b0, prev_stall = 1'b0;
  int         h_idx, h_data;
  always @(negedge clock) begin
    if (reset) begin
      prev_fire  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("block_done", int'(block_done), int'(prev_fire));
      if (prev_stall) begin
        chk("hold_valid", int'(coef_valid), 1);
        chk("hold_index", int'(coef_index), h_idx);
        chk("hold_data", int'($signed(coef_data)), h_data);
      end
      if (coef_valid && coef_ready) begin
        if (sb.size() == 0) fail_now("extra_beat", int'(coef_index));
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("beat_index", int'(coef_index), e.idx);
          chk("beat_data", int'($signed(coef_data)), e.data);
          chk("beat_last", int'(coef_last), int'(e.last));
        end
      end
      prev_fire  = coef_valid && coef_ready && coef_last;
      prev_stall = coef_valid && !coef_ready;
      h_idx      = int'(coef_index);
      h_data     = int'($signed(coef_data));
    end
  end

  task automatic scramble_inputs();
    for (int a = 0; a < 64; a++) dct_data[a] = 10'($urandom_range(0, 1023));
  endtask

  task automatic strobe_now(input blk_t blk);
    dct_valid = 1'b1;
    dct_data  = blk;
    @(posedge clock);
    #1 dct_valid = 1'b0;
    scramble_inputs();
  endtask

  task automatic strobe(input blk_t blk);
    @(posedge clock);
    #1 strobe_now(blk);
  endtask

  // Called just after the sampling edge: beat 0 must appear after the second edge.
  task automatic check_latency();
    @(negedge clock);
    chk("busy_after_capture", int'(busy), 1);
    chk("valid_edge0", int'(coef_valid), 0);
    @(negedge clock);
    chk("valid_edge1", int'(coef_valid), 0);
    @(negedge clock);
    chk("valid_edge2", int'(coef_valid), 1);
    chk("first_index", int'(coef_index), 0);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clock);
      if (block_done) seen = 1'b1;
    end
    if (!seen) fail_now("block_done_timeout", 0);
    chk("sb_drained", sb.size(), 0);
    chk("busy_at_done", int'(busy), 0);
  endtask

  task automatic wait_index(input int idx);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clock);
      if (coef_valid && int'(coef_index) == idx) seen = 1'b1;
    end
    if (!seen) fail_now("index_timeout", idx);
  endtask

  initial begin
    automatic blk_t blk;
    automatic int c0;
    build_model();
    scramble_inputs();
    #3 reset = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(coef_valid), 0);
    chk("rst_data", int'(coef_data), 0);
    chk("rst_index", int'(coef_index), 0);
    chk("rst_last", int'(coef_last), 0);
    chk("rst_done", int'(block_done), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // All zeros, ready held: latency and 64-beat throughput.
    ready_mode = 1'b0;
    for (int a = 0; a < 64; a++) blk[a] = '0;
    push_expected(blk);
    strobe(blk);
    check_latency();
    c0 = cyc;
    wait_done();
    chk("done_cycle", cyc - c0, 64);

    // DC only.
    blk[0] = 10'd200;
    push_expected(blk);
    strobe(blk);
    check_latency();
    wait_done();

    // Rounding and the -512 magnitude corner.
    blk[0] = '0;
    blk[1] = 10'h3EF;   // -17
    blk[8] = 10'h200;   // -512
    blk[63] = 10'd511;
    push_expected(blk);
    strobe(blk);
    check_latency();
    wait_done();

    // Ramp and random blocks under random backpressure.
    ready_mode = 1'b1;
    for (int a = 0; a < 64; a++) blk[a] = 10'(a);
    push_expected(blk);
    strobe(blk);
    check_latency();
    wait_done();
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 64; a++) blk[a] = 10'($urandom_range(0, 1023));
      push_expected(blk);
      strobe(blk);
      check_latency();
      wait_done();
    end

    // Strobe while busy is dropped; strobe in the done cycle is taken.
    ready_mode = 1'b0;
    for (int a = 0; a < 64; a++) blk[a] = 10'($urandom_range(0, 1023));
    push_expected(blk);
    strobe(blk);
    wait_index(10);
    for (int a = 0; a < 64; a++) blk[a] = 10'($urandom_range(0, 1023));
    strobe_now(blk);
    wait_done();
    for (int a = 0; a < 64; a++) blk[a] = 10'($urandom_range(0, 1023));
    push_expected(blk);
    strobe_now(blk);
    check_latency();
    wait_done();

    // Reset mid-block, then a fresh block restarts at index 0.
    for (int a = 0; a < 64; a++) blk[a] = 10'($urandom_range(0, 1023));
    push_expected(blk);
    strobe(blk);
    wait_index(30);
    reset = 1'b1;
    #1;
    chk("midrst_valid", int'(coef_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_index", int'(coef_index), 0);
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int a = 0; a < 64; a++) blk[a] = 10'($urandom_range(0, 1023));
    push_expected(blk);
    strobe(blk);
    check_latency();
    wait_done();

    repeat (4) @(negedge clock);
    chk("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
